// File: rtl/apb_multi_master_if.sv
// APB bus bundle between the multi-master bridge (master modport) and its peripherals (slave modport).
interface apb_multi_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLAVES = 4
);
  logic [ADDR_WIDTH-1:0]            PADDR;
  logic [NUM_SLAVES-1:0]            PSEL;
  logic                             PENABLE;
  logic                             PWRITE;
  logic [DATA_WIDTH-1:0]            PWDATA;
  logic [DATA_WIDTH/8-1:0]          PSTRB;
  logic [2:0]                       PPROT;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]            PREADY;
  logic [NUM_SLAVES-1:0]            PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_multi_master.sv
// APB master bridge: command FIFO -> address decode -> SETUP/ACCESS transfer -> one-entry response.
// Optional ACCESS wait limit enabled by defining APB_TIMEOUT_EN.

// Per-slave return gate: passes a slave's return channel only while it is selected.
module apb_mm_rtn #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ready,
  output logic                  err
);
  assign rdata = sel ? prdata : '0;
  assign ready = sel & pready;
  assign err   = sel & pslverr;
endmodule

module apb_multi_master #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int NUM_SLAVES      = 4,
  parameter int SLAVE_ADDR_BITS = 12,
  parameter int CMD_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  apb_multi_master_if.master      apb
);
  localparam int STRB_W = DATA_WIDTH/8;
  localparam int PW     = $clog2(CMD_DEPTH);

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     strb;
    logic [2:0]            prot;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;

  // ---------------- command FIFO ----------------
  cmd_t          fifo_mem [CMD_DEPTH];
  cmd_t          cmd_in, head;
  logic [PW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, push, pop;

  assign cmd_in     = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata,
                        strb: cmd_strb, prot: cmd_prot};
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign cmd_ready  = !fifo_full;
  // A pop in the same cycle never frees a slot for a push while full.
  assign push       = cmd_valid && !fifo_full;
  assign head       = fifo_mem[rd_ptr[PW-1:0]];

  always_ff @(posedge PCLK) begin
    if (push) fifo_mem[wr_ptr[PW-1:0]] <= cmd_in;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // ---------------- decode ----------------
  logic [ADDR_WIDTH-1:0] head_idx;
  logic [NUM_SLAVES-1:0] head_sel;
  logic                  decode_ok;

  assign head_idx  = head.addr >> SLAVE_ADDR_BITS;
  // Out-of-range index shifts the one-hot bit off the top, leaving zero.
  assign head_sel  = NUM_SLAVES'(1) << head_idx;
  assign decode_ok = |head_sel;

  // ---------------- selected slave return channel ----------------
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0] rtn_rdata;
  logic [NUM_SLAVES-1:0]                 rtn_ready, rtn_err;
  logic [NUM_SLAVES*DATA_WIDTH-1:0]      prdata_all;
  logic [NUM_SLAVES-1:0]                 psel_q, pready_all, pslverr_all;
  logic [DATA_WIDTH-1:0]                 sel_rdata;
  logic                                  sel_ready, sel_err;

  assign prdata_all  = apb.PRDATA;
  assign pready_all  = apb.PREADY;
  assign pslverr_all = apb.PSLVERR;
  assign psel_q      = apb.PSEL;

  apb_mm_rtn #(.DATA_WIDTH(DATA_WIDTH)) u_rtn [NUM_SLAVES-1:0] (
    .sel     (psel_q),
    .prdata  (prdata_all),
    .pready  (pready_all),
    .pslverr (pslverr_all),
    .rdata   (rtn_rdata),
    .ready   (rtn_ready),
    .err     (rtn_err)
  );

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) sel_rdata = sel_rdata | rtn_rdata[i];
  end
  assign sel_ready = |rtn_ready;
  assign sel_err   = |rtn_err;

  // ---------------- FSM state register ----------------
  state_e state_q, state_d;
  logic   dispatch, tmo_hit;

  assign dispatch = !fifo_empty && (!rsp_valid || rsp_ready);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

`ifdef APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Counts ACCESS cycles with PREADY low; cleared on the SETUP->ACCESS edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                            tmo_cnt <= '0;
    else if (state_q == SETUP)               tmo_cnt <= '0;
    else if (state_q == ACCESS && !sel_ready) tmo_cnt <= tmo_cnt + TW'(1);
  end
  assign tmo_hit = (state_q == ACCESS) && !sel_ready && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // ---------------- FSM next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dispatch && decode_ok) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (sel_ready || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM outputs ----------------
  logic                  bus_load, rsp_load, rsp_err_d, penable_d;
  logic [NUM_SLAVES-1:0] psel_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  always_comb begin
    pop         = 1'b0;
    bus_load    = 1'b0;
    rsp_load    = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    psel_d      = psel_q;
    penable_d   = apb.PENABLE;
    case (state_q)
      IDLE: if (dispatch) begin
        pop = 1'b1;
        if (decode_ok) begin
          bus_load  = 1'b1;
          psel_d    = head_sel;
          penable_d = 1'b0;
        end else begin
          rsp_load  = 1'b1;
          rsp_err_d = 1'b1;
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: if (sel_ready) begin
        rsp_load    = 1'b1;
        rsp_err_d   = sel_err;
        rsp_rdata_d = (!apb.PWRITE && !sel_err) ? sel_rdata : '0;
        psel_d      = '0;
        penable_d   = 1'b0;
      end else if (tmo_hit) begin
        rsp_load  = 1'b1;
        rsp_err_d = 1'b1;
        psel_d    = '0;
        penable_d = 1'b0;
      end
      default: ;
    endcase
  end

  // ---------------- registered bus and response ----------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      apb.PSEL    <= '0;
      apb.PENABLE <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWRITE  <= 1'b0;
      apb.PWDATA  <= '0;
      apb.PSTRB   <= '0;
      apb.PPROT   <= '0;
      rsp_valid   <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      apb.PSEL    <= psel_d;
      apb.PENABLE <= penable_d;
      if (bus_load) begin
        apb.PADDR  <= head.addr;
        apb.PWRITE <= head.write;
        apb.PWDATA <= head.wdata;
        apb.PSTRB  <= head.write ? head.strb : '0;
        apb.PPROT  <= head.prot;
      end
      if (rsp_load) begin
        rsp_valid <= 1'b1;
        rsp_err   <= rsp_err_d;
        rsp_rdata <= rsp_rdata_d;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_apb_multi_master.sv
// Bench for apb_multi_master: directed scenarios plus randomized traffic against a queue-based model.
module tb_apb_multi_master;
  localparam int TMO = 16;

  logic        PCLK, PRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  apb_multi_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLAVES(4)) apb ();

  apb_multi_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_SLAVES(4),
    .SLAVE_ADDR_BITS(12), .CMD_DEPTH(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .apb(apb)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic wr; logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; logic [2:0] prot;
    int idx; int waits; logic err; logic [31:0] rdata;
  } beh_t;
  typedef struct { logic err; logic [31:0] rdata; } exp_t;

  beh_t beh_q[$];
  exp_t exp_q[$];
  int   n_cmp = 0, n_mis = 0;
  int   n_setup = 0;
  int   rdy_mode = 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: each command's outcome follows from its address and the slave behaviour chosen for it.
  task automatic push_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input int waits,
                          input logic err, input logic [31:0] rdata);
    beh_t b; exp_t e; int idx; logic acc;
    idx = int'(addr >> 12);
    if (idx >= 4) begin
      e.err = 1'b1; e.rdata = '0;
    end else begin
      b.wr = wr; b.addr = addr; b.wdata = wdata; b.strb = strb; b.prot = prot;
      b.idx = idx; b.waits = waits; b.err = err; b.rdata = rdata;
      beh_q.push_back(b);
      e.err = err; e.rdata = (!wr && !err) ? rdata : 32'h0;
`ifdef APB_TIMEOUT_EN
      if (waits >= TMO) begin e.err = 1'b1; e.rdata = '0; end
`endif
    end
    exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    cmd_strb = strb; cmd_prot = prot;
    acc = 1'b0;
    for (int n = 0; n < 200 && !acc; n++) begin
      acc = cmd_ready;
      @(posedge PCLK); #1;
    end
    cmd_valid = 1'b0;
    if (!acc) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || beh_q.size() != 0) && n < budget) begin
      @(posedge PCLK); #1; n++;
    end
    chk("drain_left", exp_q.size() + beh_q.size(), 0);
    @(posedge PCLK); #1;
  endtask

  task automatic wait_access();
    int n;
    n = 0;
    while (!(apb.PENABLE && apb.PSEL != 4'b0) && n < 40) begin @(posedge PCLK); #1; n++; end
    chk("reach_access", apb.PENABLE, 1);
  endtask

  task automatic mid_reset();
    #3 PRESETn = 1'b0;
    #1;
    exp_q.delete(); beh_q.delete();
    chk("rst_async", {apb.PSEL, apb.PENABLE, rsp_valid, cmd_ready}, {4'b0, 1'b0, 1'b0, 1'b1});
    repeat (2) @(posedge PCLK);
    #4 PRESETn = 1'b1;
    @(posedge PCLK); #1;
  endtask

  // Slave side: checks SETUP contents, bus stability in ACCESS, and drives the scripted reply.
  initial begin
    beh_t cur; int wait_left; bit busy;
    logic [75:0] snap;
    apb.PREADY = '0; apb.PSLVERR = '0; apb.PRDATA = '0;
    busy = 0; wait_left = 0;
    forever begin
      @(posedge PCLK); #2;
      apb.PREADY  = 4'($urandom);
      apb.PSLVERR = 4'($urandom);
      apb.PRDATA  = {$urandom, $urandom, $urandom, $urandom};
      if (!PRESETn) busy = 0;
      else if (apb.PSEL != 4'b0 && !apb.PENABLE) begin
        n_setup++;
        if (beh_q.size() == 0) begin
          chk("slv_unexpected_setup", 1, 0);
          busy = 0;
        end else begin
          logic [3:0] oh;
          cur = beh_q.pop_front();
          busy = 1; wait_left = cur.waits;
          oh = 4'b1 << cur.idx;
          chk("setup_psel", apb.PSEL, oh);
          chk("setup_paddr", apb.PADDR, cur.addr);
          chk("setup_pwrite", apb.PWRITE, cur.wr);
          chk("setup_pwdata", apb.PWDATA, cur.wdata);
          chk("setup_pstrb", apb.PSTRB, cur.wr ? cur.strb : 4'h0);
          chk("setup_pprot", apb.PPROT, cur.prot);
          snap = {apb.PADDR, apb.PWRITE, apb.PWDATA, apb.PSTRB, apb.PPROT, apb.PSEL, 1'b1};
        end
      end else if (apb.PSEL != 4'b0 && busy) begin
        chk("access_stable",
            {apb.PADDR, apb.PWRITE, apb.PWDATA, apb.PSTRB, apb.PPROT, apb.PSEL, apb.PENABLE}, snap);
        if (wait_left == 0) begin
          apb.PREADY[cur.idx]  = 1'b1;
          apb.PSLVERR[cur.idx] = cur.err;
          apb.PRDATA[cur.idx*32 +: 32] = cur.rdata;
        end else begin
          apb.PREADY[cur.idx] = 1'b0;
          wait_left--;
        end
      end else busy = 0;
    end
  end

  // Response side: drives rsp_ready and scores each accepted response in order.
  initial begin
    exp_t e;
    rsp_ready = 1'b0;
    forever begin
      @(posedge PCLK); #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
      if (PRESETn && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_bus", {apb.PSEL, apb.PENABLE, apb.PWRITE, apb.PSTRB, apb.PPROT}, 0);
    chk("rst_paddr_pwdata", {apb.PADDR, apb.PWDATA}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    #3 PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Zero-wait write to slave 1, cycle by cycle.
    push_cmd(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 1'b0, 32'h0);
    chk("wr_e0_psel", apb.PSEL, 0);
    @(posedge PCLK); #1;
    chk("wr_e1", {apb.PSEL, apb.PENABLE, apb.PSTRB}, {4'b0010, 1'b0, 4'hF});
    @(posedge PCLK); #1;
    chk("wr_e2", {apb.PSEL, apb.PENABLE}, {4'b0010, 1'b1});
    @(posedge PCLK); #1;
    chk("wr_e3", {apb.PSEL, apb.PENABLE, rsp_valid}, {4'b0000, 1'b0, 1'b1});
    drain(50);

    // Read from slave 3 with three wait states.
    push_cmd(1'b0, 32'h0000_3000, 32'h0, 4'h3, 3'b000, 3, 1'b0, 32'h1234_5678);
    drain(50);

    // Decode error: no bus activity, response one edge after dispatch.
    rdy_mode = 0; n0 = n_setup;
    push_cmd(1'b0, 32'h0000_5000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h0);
    chk("dec_e0_rsp", rsp_valid, 0);
    @(posedge PCLK); #1;
    chk("dec_e1", {rsp_valid, rsp_err, apb.PSEL}, {1'b1, 1'b1, 4'b0});
    rdy_mode = 1;
    drain(50);
    chk("dec_no_setup", n_setup - n0, 0);

    // Backpressure: response held, FIFO fills, only one transfer runs.
    rdy_mode = 0; n0 = n_setup;
    for (int k = 0; k < 5; k++)
      push_cmd(1'(k & 1), 32'(k % 4) << 12, 32'hA000_0000 + 32'(k), 4'h5, 3'(k), 0, 1'b0,
               32'hB000_0000 + 32'(k));
    chk("full_cmd_ready", cmd_ready, 0);
    repeat (10) begin @(posedge PCLK); #1; end
    chk("full_one_xfer", n_setup - n0, 1);
    chk("full_held", {rsp_valid, cmd_ready}, {1'b1, 1'b0});
    rdy_mode = 2;
    drain(400);
    rdy_mode = 1;

    // Slave error on a read masks the data.
    push_cmd(1'b0, 32'h0000_0040, 32'h0, 4'hF, 3'b001, 1, 1'b1, 32'hCAFE_F00D);
    drain(50);

    // Slave 2 never ready.
    push_cmd(1'b0, 32'h0000_2000, 32'h0, 4'h0, 3'b000, 1000000, 1'b0, 32'h5555_AAAA);
    wait_access();
`ifdef APB_TIMEOUT_EN
    rdy_mode = 0;
    repeat (TMO - 1) begin @(posedge PCLK); #1; end
    chk("tmo_before", apb.PSEL, 4'b0100);
    @(posedge PCLK); #1;
    chk("tmo_abandon", {apb.PSEL, apb.PENABLE, rsp_valid, rsp_err}, {4'b0, 1'b0, 1'b1, 1'b1});
    rdy_mode = 1;
    drain(50);
`else
    repeat (100) begin @(posedge PCLK); #1; end
    chk("no_tmo_still_access", {apb.PSEL, apb.PENABLE}, {4'b0100, 1'b1});
    mid_reset();
`endif

    // Reset in the middle of ACCESS with commands queued behind.
    push_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b000, 8, 1'b0, 32'h1111_2222);
    push_cmd(1'b1, 32'h0000_1000, 32'h3333_4444, 4'hC, 3'b000, 0, 1'b0, 32'h0);
    push_cmd(1'b0, 32'h0000_2000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'h7777_8888);
    wait_access();
    n0 = n_setup;
    mid_reset();
    repeat (6) begin @(posedge PCLK); #1; end
    chk("rst_fifo_empty", {n_setup - n0, apb.PSEL, rsp_valid, cmd_ready}, {32'd0, 4'b0, 1'b0, 1'b1});

    // Randomized traffic, including decode errors and random response backpressure.
    rdy_mode = 2;
    for (int k = 0; k < 80; k++) begin
      int idx; logic [31:0] a;
      idx = $urandom_range(0, 5);
      a = (32'(idx) << 12) | ($urandom & 32'h0000_0FFC);
      push_cmd(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 3'($urandom),
               $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom);
      repeat ($urandom_range(0, 2)) begin @(posedge PCLK); #1; end
    end
    drain(3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/apb_multi_master.md
# apb_multi_master

Parametrised APB master bridge, successor to the single-slot two-slave APB bus block. A valid/ready command port feeds a command FIFO, and addresses are decoded to one of NUM_SLAVES PSEL lines. Each command runs as a standard SETUP/ACCESS transfer, and the result is returned on a valid/ready response port. It sits between the CPU-side request logic and the peripheral slaves (GPIO, UART, ...).

## Interface
- DATA_WIDTH, 32, PWDATA/PRDATA width; a multiple of 8.
- ADDR_WIDTH, 32, address width.
- NUM_SLAVES, 4, number of PSEL lines and slave return channels.
- SLAVE_ADDR_BITS, 12, region size in address bits; slave index = cmd_addr >> SLAVE_ADDR_BITS.
- CMD_DEPTH, 4, command FIFO depth; a power of 2, at least 2.
- TIMEOUT_CYCLES, 16, ACCESS wait limit; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock.
- PRESETn  in  1  reset, asynchronous, active-low.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid / rsp_ready  out / in  1  response handshake.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_err  out  1  slave error, decode error or timeout.
- PADDR  out  ADDR_WIDTH.
- PSEL  out  NUM_SLAVES  one-hot or zero.
- PENABLE, PWRITE  out  1.
- PWDATA  out  DATA_WIDTH.
- PSTRB  out  DATA_WIDTH/8.
- PPROT  out  3.
- PRDATA  in  NUM_SLAVES*DATA_WIDTH  slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- PREADY, PSLVERR  in  NUM_SLAVES  one bit per slave.

## Operation
- **Command FIFO**
  - cmd_ready = !full.
  - Push on cmd_valid && cmd_ready.
  - When full, no push and no bypass, even if a pop occurs in the same cycle.
- **FSM states:** IDLE, SETUP, ACCESS.
- **IDLE, dispatch:** when the FIFO is non-empty and the response slot is free (!rsp_valid || rsp_ready):
  - Head index < NUM_SLAVES: pop, then register PADDR, PWRITE, PWDATA and PPROT from the head entry.
  - PSTRB = cmd_strb for writes, all zeros for reads.
  - PSEL[index] = 1, PENABLE = 0, go to SETUP.
  - Head index >= NUM_SLAVES: pop, load response (err = 1, rdata = 0) and stay in IDLE; no bus activity.
- **SETUP:** PENABLE = 1, go to ACCESS.
- **ACCESS:** only the selected slave's PREADY, PSLVERR and PRDATA are observed.
  - PREADY = 0: hold all bus outputs stable.
  - PREADY = 1: load the response register.
    - rsp_err = PSLVERR[index].
    - rsp_rdata = PRDATA slice when this is a read with no error, else 0.
  - Also on PREADY = 1: drive PSEL = 0 and PENABLE = 0, go to IDLE.
  - PADDR, PWRITE, PWDATA, PSTRB and PPROT keep their last values.
- **Response register:** one entry. rsp_valid is held until rsp_ready. A new response is never loaded while rsp_valid && !rsp_ready.

## Timing
- **Reset:** all APB outputs 0, rsp_valid/rsp_rdata/rsp_err 0, FIFO empty, state IDLE, so cmd_ready = 1.
- **Reset mid-transfer:** PSEL and PENABLE drop asynchronously. Queued commands and any pending response are discarded.
- All outputs are registered except cmd_ready.
- **Zero-wait-state latency:**
  - Command accepted at edge E.
  - PSEL high after E+1.
  - PENABLE high after E+2.
  - PREADY sampled at E+3.
  - rsp_valid high after E+3.
- **Throughput:** minimum 3 cycles per transfer, since every transfer returns to IDLE.
- **Decode error:** rsp_valid high one edge after dispatch.
- A simultaneous push and pop on a non-full FIFO leaves the occupancy unchanged.

## Configuration
- **APB_TIMEOUT_EN defined:**
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY = 0.
  - When PREADY has been low for TIMEOUT_CYCLES consecutive ACCESS cycles, the transfer is abandoned.
  - Abandon action: response err = 1, rdata = 0; PSEL and PENABLE = 0 at the same edge; go to IDLE.
- **APB_TIMEOUT_EN undefined:** ACCESS waits indefinitely for PREADY; no counter logic is present.

## Test plan
- Write 0x0000_1004, data 0xDEADBEEF, strb 0xF, slave 1 ready immediately -> PSEL = 0b0010 for 2 cycles, PENABLE in cycle 2, PSTRB = 0xF; response err = 0, rdata = 0.
- Read 0x0000_3000 with slave 3 holding PREADY low for 3 cycles, then PRDATA = 0x12345678 -> bus outputs stable through the wait; response rdata = 0x12345678.
- Read 0x0000_5000 with NUM_SLAVES = 4 -> PSEL never asserts; response err = 1 one cycle after dispatch.
- Push 5 commands back-to-back while rsp_ready = 0 -> cmd_ready drops after 4 are queued. Only the first transfer runs until rsp_ready rises, then transfers proceed in order.
- Slave 0 asserts PSLVERR = 1 with PREADY on a read -> rsp_err = 1, rsp_rdata = 0. Assert PRESETn low mid-ACCESS -> PSEL/PENABLE = 0 immediately, FIFO empty.
- APB_TIMEOUT_EN defined, slave 2 never ready -> after 16 ACCESS cycles, response err = 1 and PSEL = 0. Without the macro, the bus is still in ACCESS after 100 cycles.
